// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle between a UART transmit client and uart_tx_frame.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 serial_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start, tx_data,
    input  serial_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data,
    output serial_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even parity, one stop bit.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 serial_out_q, serial_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 last_cyc_c;

  assign last_cyc_c = (cyc_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '1;
      par_q        <= 1'b0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state and counters; every bit lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          state_d = START;
          shreg_d = bus.tx_data;
          par_d   = ^bus.tx_data;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (last_cyc_c) begin
          state_d = DATA;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (last_cyc_c) begin
          cyc_d   = '0;
          shreg_d = {1'b1, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      PARITY: begin
        if (last_cyc_c) begin
          state_d = STOP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (last_cyc_c) begin
          state_d = IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are registered from the upcoming state so the line level changes on the accepting edge.
    case (state_d)
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shreg_d[0];
      PARITY:  serial_out_d = par_d;
      default: serial_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.serial_out = serial_out_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a no-parity and an even-parity instance driven side by side.
module tb_uart_tx_frame;
  localparam int unsigned CPB = 10;

  typedef struct {
    logic [7:0] data;
    logic [9:0] wave;   // line level per bit time, index 0 = start bit
    logic       par;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_tx_frame_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) bus1 ();

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: frame bit list plus cycle index into the frame.
  logic        m_active [2];
  int          m_k      [2];
  logic [15:0] m_bits   [2];
  logic        e_so     [2];
  logic        e_busy   [2];
  logic        e_done   [2];
  int          done_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_k[d]      = 0;
      m_bits[d]   = '1;
    end
  endtask

  task automatic model_step(input int d, input logic st, input logic [7:0] dat);
    int nbits;
    nbits     = (d == 1) ? 11 : 10;
    e_done[d] = 1'b0;
    if (m_active[d]) begin
      m_k[d] = m_k[d] + 1;
      if (m_k[d] >= nbits * int'(CPB)) begin
        m_active[d] = 1'b0;
        e_done[d]   = 1'b1;
      end
    end else if (st) begin
      m_bits[d]    = '1;
      m_bits[d][0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[d][i+1] = dat[i];
      if (d == 1) m_bits[d][9] = ($countones(dat) % 2) == 1;
      m_active[d] = 1'b1;
      m_k[d]      = 0;
    end
    e_busy[d] = m_active[d];
    e_so[d]   = m_active[d] ? m_bits[d][m_k[d] / int'(CPB)] : 1'b1;
  endtask

  task automatic drive(input logic st, input logic [7:0] dat);
    bus0.tx_start = st;
    bus0.tx_data  = dat;
    bus1.tx_start = st;
    bus1.tx_data  = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, bus0.tx_start, bus0.tx_data);
    model_step(1, bus1.tx_start, bus1.tx_data);
    #1;
    chk("so0",   32'(bus0.serial_out), 32'(e_so[0]));
    chk("busy0", 32'(bus0.tx_busy),    32'(e_busy[0]));
    chk("done0", 32'(bus0.tx_done),    32'(e_done[0]));
    chk("so1",   32'(bus1.serial_out), 32'(e_so[1]));
    chk("busy1", 32'(bus1.tx_busy),    32'(e_busy[1]));
    chk("done1", 32'(bus1.tx_done),    32'(e_done[1]));
    if (bus0.tx_done) done_cnt[0]++;
    if (bus1.tx_done) done_cnt[1]++;
  endtask

  task automatic check_idle_now(input string tag);
    chk({tag, "_so0"},   32'(bus0.serial_out), 32'd1);
    chk({tag, "_busy0"}, 32'(bus0.tx_busy),    32'd0);
    chk({tag, "_done0"}, 32'(bus0.tx_done),    32'd0);
    chk({tag, "_so1"},   32'(bus1.serial_out), 32'd1);
    chk({tag, "_busy1"}, 32'(bus1.tx_busy),    32'd0);
    chk({tag, "_done1"}, 32'(bus1.tx_done),    32'd0);
  endtask

  // Hold reset across two edges, then release away from the active edge.
  task automatic finish_reset();
    model_clear();
    drive(1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One strobe, then check mid-bit levels, busy length and done position against the table.
  task automatic run_frame(input vec_t v);
    int   done0_k, done1_k, busy0, busy1, b;
    logic exp1;
    done0_k = -1; done1_k = -1; busy0 = 0; busy1 = 0;
    drive(1'b1, v.data);
    tick();
    drive(1'b0, 8'h00);
    for (int k = 0; k < 112; k++) begin
      if (k > 0) tick();
      if (bus0.tx_busy) busy0++;
      if (bus1.tx_busy) busy1++;
      if (bus0.tx_done && done0_k < 0) done0_k = k;
      if (bus1.tx_done && done1_k < 0) done1_k = k;
      if ((k % int'(CPB)) == int'(CPB) / 2) begin
        b = k / int'(CPB);
        if (b < 10) chk("tbl_bit0", 32'(bus0.serial_out), 32'(v.wave[b]));
        if (b < 9)       exp1 = v.wave[b];
        else if (b == 9) exp1 = v.par;
        else             exp1 = 1'b1;
        if (b < 11) chk("tbl_bit1", 32'(bus1.serial_out), 32'(exp1));
      end
    end
    chk("tbl_busy_len0", 32'(busy0),   32'd100);
    chk("tbl_busy_len1", 32'(busy1),   32'd110);
    chk("tbl_done_at0",  32'(done0_k), 32'd100);
    chk("tbl_done_at1",  32'(done1_k), 32'd110);
  endtask

  vec_t vt [6];
  int   d0, d1;

  initial begin
    checks = 0; errors = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst = 1'b0;
    drive(1'b0, 8'h00);
    model_clear();

    vt[0] = '{data: 8'hA5, wave: 10'b1101001010, par: 1'b0};
    vt[1] = '{data: 8'h07, wave: 10'b1000001110, par: 1'b1};
    vt[2] = '{data: 8'h00, wave: 10'b1000000000, par: 1'b0};
    vt[3] = '{data: 8'hFF, wave: 10'b1111111110, par: 1'b0};
    vt[4] = '{data: 8'h80, wave: 10'b1100000000, par: 1'b1};
    vt[5] = '{data: 8'h3C, wave: 10'b1001111000, par: 1'b0};

    // Reset asserted between edges must take effect at once.
    #2 rst = 1'b1;
    #1 check_idle_now("rst_async");
    finish_reset();

    for (int i = 0; i < 6; i++) run_frame(vt[i]);

    // Strobe and data changes while busy must not disturb or queue a frame.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    drive(1'b1, 8'hA5);
    tick();
    drive(1'b0, 8'hA5);
    for (int k = 1; k < 125; k++) begin
      if (k == 30) drive(1'b1, 8'hFF);
      if (k == 36) drive(1'b0, 8'h12);
      tick();
      if (k == 45) chk("rej_bit3", 32'(bus0.serial_out), 32'd0);
    end
    chk("rej_frames0", 32'(done_cnt[0] - d0), 32'd1);
    chk("rej_frames1", 32'(done_cnt[1] - d1), 32'd1);

    // tx_start held high: second frame starts on the cycle after the done pulse.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    drive(1'b1, 8'h55);
    tick();
    drive(1'b1, 8'h0F);
    for (int k = 1; k < 240; k++) begin
      if (k == 115) drive(1'b0, 8'h00);
      tick();
      if (k == 100) chk("b2b_done0", 32'(bus0.tx_done), 32'd1);
      if (k == 101) begin
        chk("b2b_start0", 32'(bus0.serial_out), 32'd0);
        chk("b2b_busy0",  32'(bus0.tx_busy),    32'd1);
      end
      if (k == 111) chk("b2b_start1", 32'(bus1.serial_out), 32'd0);
      if (k == 116) chk("b2b_d0_0f",  32'(bus0.serial_out), 32'd1);
      if (k == 156) chk("b2b_d4_0f",  32'(bus0.serial_out), 32'd0);
    end
    chk("b2b_frames0", 32'(done_cnt[0] - d0), 32'd2);
    chk("b2b_frames1", 32'(done_cnt[1] - d1), 32'd2);

    // Reset in the middle of data bit 3 abandons the frame without a done pulse.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    drive(1'b1, 8'hC3);
    tick();
    drive(1'b0, 8'h00);
    for (int k = 1; k <= 45; k++) tick();
    #3 rst = 1'b1;
    #1 check_idle_now("rst_mid");
    finish_reset();
    for (int k = 0; k < 20; k++) tick();
    chk("rst_nodone0", 32'(done_cnt[0] - d0), 32'd0);
    chk("rst_nodone1", 32'(done_cnt[1] - d1), 32'd0);
    run_frame(vt[5]);

    // Random strobes and data against the model.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 7) == 0, 8'($urandom));
      tick();
    end
    drive(1'b0, 8'h00);
    for (int k = 0; k < 120; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
